ec_scalar_mul_ctrl: RTL

//  Sequencer that computes R = k*P on y^2 = x^3 + a*x + b (mod prime) by left-to-right double-and-add.

---
 rtl/ec_scalar_mul_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ec_scalar_mul_ctrl.sv
// ---------------------------------------------------------------------------
// ec_scalar_mul_ctrl
//   Sequencer for R = k*P on y^2 = x^3 + a*x + b (mod prime) using
//   left-to-right double-and-add. Each double or add that needs real field
//   arithmetic is handed to a shared external point-add unit over a
//   request/response handshake. The point-at-infinity and P + (-P) cases
//   are resolved here, so the point-add unit only ever sees finite, non-
//   inverse operands. Coordinates are only compared and copied here.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid              1-cycle start pulse (accepted in IDLE only)
//   in_Px/in_Py           base point P
//   in_k                  scalar k
//   in_prime, in_a        field prime and curve coefficient a
//   pa_in_valid           1-cycle request to the point-add unit
//   pa_Px/Py, pa_Qx/Qy    request operands (0 when no request)
//   pa_prime, pa_a        forwarded field parameters (0 when no request)
//   pa_out_valid          point-add result strobe
//   pa_Rx/pa_Ry           point-add result
//   out_valid             1-cycle result strobe
//   out_Rx/out_Ry         result point (0 when out_valid low or infinity)
//   out_inf               result is the point at infinity
//   out_err               (EC_TIMEOUT_EN only) point-add request timed out
//
// Configuration
//   EC_TIMEOUT_EN  adds a per-request watchdog of TIMEOUT cycles in the
//                  wait states and the out_err port. Without it the wait
//                  states block until the point-add unit answers.
// ---------------------------------------------------------------------------
module ec_scalar_mul_ctrl #(
  parameter int W       = 6,
  parameter int KW      = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_Px,
  input  logic [W-1:0]  in_Py,
  input  logic [KW-1:0] in_k,
  input  logic [W-1:0]  in_prime,
  input  logic [W-1:0]  in_a,
  output logic          pa_in_valid,
  output logic [W-1:0]  pa_Px,
  output logic [W-1:0]  pa_Py,
  output logic [W-1:0]  pa_Qx,
  output logic [W-1:0]  pa_Qy,
  output logic [W-1:0]  pa_prime,
  output logic [W-1:0]  pa_a,
  input  logic          pa_out_valid,
  input  logic [W-1:0]  pa_Rx,
  input  logic [W-1:0]  pa_Ry,
  output logic          out_valid,
  output logic [W-1:0]  out_Rx,
  output logic [W-1:0]  out_Ry,
  output logic          out_inf
`ifdef EC_TIMEOUT_EN
  ,
  output logic          out_err
`endif
);

  localparam int CW = $clog2(KW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  px_q, px_d, py_q, py_d, prime_q, prime_d, a_q, a_d;
  logic [KW-1:0] k_q, k_d;            // scalar, shifted left; MSB is current bit
  logic [CW-1:0] bits_q, bits_d;      // scalar bits still to process
  logic          dbl_done_q, dbl_done_d;  // double of current bit already done
  logic [W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic          acc_inf_q, acc_inf_d;
  logic          pa_valid_q, pa_valid_d;
  logic [W-1:0]  pa_px_q, pa_px_d, pa_py_q, pa_py_d;
  logic [W-1:0]  pa_qx_q, pa_qx_d, pa_qy_q, pa_qy_d;
  logic [W-1:0]  pa_prime_q, pa_prime_d, pa_a_q, pa_a_d;
  logic          out_valid_q, out_valid_d, out_inf_q, out_inf_d;
  logic [W-1:0]  out_rx_q, out_rx_d, out_ry_q, out_ry_d;
`ifdef EC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          out_err_q, out_err_d;
`endif

  // Accumulator after the (possibly local) double step of SCAN.
  logic [W-1:0] step_x, step_y;
  logic         step_inf, need_dbl;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    prime_d    = prime_q;
    a_d        = a_q;
    k_d        = k_q;
    bits_d     = bits_q;
    dbl_done_d = dbl_done_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_inf_d  = acc_inf_q;
    // Request and result outputs are pulses: zero unless set below.
    pa_valid_d = 1'b0;
    pa_px_d    = '0;
    pa_py_d    = '0;
    pa_qx_d    = '0;
    pa_qy_d    = '0;
    pa_prime_d = '0;
    pa_a_d     = '0;
    out_valid_d = 1'b0;
    out_rx_d    = '0;
    out_ry_d    = '0;
    out_inf_d   = 1'b0;
    step_x   = acc_x_q;
    step_y   = acc_y_q;
    step_inf = acc_inf_q;
    need_dbl = 1'b0;
`ifdef EC_TIMEOUT_EN
    tmr_d     = tmr_q;
    out_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          px_d       = in_Px;
          py_d       = in_Py;
          k_d        = in_k;
          prime_d    = in_prime;
          a_d        = in_a;
          acc_x_d    = '0;
          acc_y_d    = '0;
          acc_inf_d  = 1'b1;
          bits_d     = CW'(KW);
          dbl_done_d = 1'b0;
          state_d    = S_SCAN;
        end
      end

      S_SCAN: begin
        if (bits_q == '0) begin
          out_valid_d = 1'b1;
          out_rx_d    = acc_inf_q ? '0 : acc_x_q;
          out_ry_d    = acc_inf_q ? '0 : acc_y_q;
          out_inf_d   = acc_inf_q;
          state_d     = S_DONE;
        end else begin
          // Double step: infinity stays infinity, y==0 doubles to infinity,
          // anything else goes to the point-add unit.
          if (!dbl_done_q && !acc_inf_q) begin
            if (acc_y_q == '0) begin
              step_x   = '0;
              step_y   = '0;
              step_inf = 1'b1;
            end else begin
              need_dbl = 1'b1;
            end
          end

          if (need_dbl) begin
            pa_valid_d = 1'b1;
            pa_px_d    = acc_x_q;
            pa_py_d    = acc_y_q;
            pa_qx_d    = acc_x_q;
            pa_qy_d    = acc_y_q;
            pa_prime_d = prime_q;
            pa_a_d     = a_q;
            dbl_done_d = 1'b1;
            state_d    = S_DBL_REQ;
          end else begin
            acc_x_d   = step_x;
            acc_y_d   = step_y;
            acc_inf_d = step_inf;
            // Add step; the bit is consumed whether or not a request follows.
            if (k_q[KW-1]) begin
              if (step_inf) begin
                acc_x_d   = px_q;
                acc_y_d   = py_q;
                acc_inf_d = 1'b0;
              end else if (step_x == px_q && step_y != py_q) begin
                // Same x, different y on a curve means acc == -P.
                acc_x_d   = '0;
                acc_y_d   = '0;
                acc_inf_d = 1'b1;
              end else begin
                pa_valid_d = 1'b1;
                pa_px_d    = step_x;
                pa_py_d    = step_y;
                pa_qx_d    = px_q;
                pa_qy_d    = py_q;
                pa_prime_d = prime_q;
                pa_a_d     = a_q;
                state_d    = S_ADD_REQ;
              end
            end
            k_d        = k_q << 1;
            bits_d     = bits_q - CW'(1);
            dbl_done_d = 1'b0;
          end
        end
      end

      S_DBL_REQ: begin
        state_d = S_DBL_WAIT;
`ifdef EC_TIMEOUT_EN
        tmr_d = '0;
`endif
      end

      S_ADD_REQ: begin
        state_d = S_ADD_WAIT;
`ifdef EC_TIMEOUT_EN
        tmr_d = '0;
`endif
      end

      S_DBL_WAIT, S_ADD_WAIT: begin
        if (pa_out_valid) begin
          acc_x_d   = pa_Rx;
          acc_y_d   = pa_Ry;
          acc_inf_d = 1'b0;
          state_d   = S_SCAN;
        end
`ifdef EC_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT - 1)) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
`endif
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      prime_q     <= '0;
      a_q         <= '0;
      k_q         <= '0;
      bits_q      <= '0;
      dbl_done_q  <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      acc_inf_q   <= 1'b1;
      pa_valid_q  <= 1'b0;
      pa_px_q     <= '0;
      pa_py_q     <= '0;
      pa_qx_q     <= '0;
      pa_qy_q     <= '0;
      pa_prime_q  <= '0;
      pa_a_q      <= '0;
      out_valid_q <= 1'b0;
      out_rx_q    <= '0;
      out_ry_q    <= '0;
      out_inf_q   <= 1'b0;
`ifdef EC_TIMEOUT_EN
      tmr_q       <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others.
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      prime_q     <= prime_d;
      a_q         <= a_d;
      k_q         <= k_d;
      bits_q      <= bits_d;
      dbl_done_q  <= dbl_done_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      acc_inf_q   <= acc_inf_d;
      pa_valid_q  <= pa_valid_d;
      pa_px_q     <= pa_px_d;
      pa_py_q     <= pa_py_d;
      pa_qx_q     <= pa_qx_d;
      pa_qy_q     <= pa_qy_d;
      pa_prime_q  <= pa_prime_d;
      pa_a_q      <= pa_a_d;
      out_valid_q <= out_valid_d;
      out_rx_q    <= out_rx_d;
      out_ry_q    <= out_ry_d;
      out_inf_q   <= out_inf_d;
`ifdef EC_TIMEOUT_EN
      tmr_q       <= tmr_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign pa_in_valid = pa_valid_q;
  assign pa_Px       = pa_px_q;
  assign pa_Py       = pa_py_q;
  assign pa_Qx       = pa_qx_q;
  assign pa_Qy       = pa_qy_q;
  assign pa_prime    = pa_prime_q;
  assign pa_a        = pa_a_q;
  assign out_valid   = out_valid_q;
  assign out_Rx      = out_rx_q;
  assign out_Ry      = out_ry_q;
  assign out_inf     = out_inf_q;
`ifdef EC_TIMEOUT_EN
  assign out_err     = out_err_q;
`endif

endmodule
